// File: rtl/mul_issue_queue.sv
// Operand issue / result-capture stage in front of a sequential 32x32 multiplier.
// Buffers operand pairs, issues one job at a time with a Run pulse, and holds the product for a valid/ready consumer.
module mul_issue_queue #(
    parameter int DEPTH    = 4,
    parameter int MIN_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [31:0] i_in_multiplier,
    input  logic [31:0] i_in_multiplicand,
    output logic        o_run,
    output logic [31:0] o_multiplier_out,
    output logic [31:0] o_multiplicand_out,
    input  logic        i_mul_ready,
    input  logic [63:0] i_product_in,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [63:0] o_out_product,
    output logic        o_busy,
    output logic [15:0] o_done_count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(MIN_WAIT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [31:0]       r_fifo_mult  [DEPTH];
    logic [31:0]       r_fifo_mcand [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [31:0]       r_op_mult;
    logic [31:0]       r_op_mcand;
    logic              r_out_valid;
    logic [63:0]       r_out_product;
    logic [15:0]       r_done_count;

    logic w_push;
    logic w_pop;
    logic w_capture;
    logic w_consume;
    logic w_fifo_nonempty;

    assign w_fifo_nonempty = (r_count != '0);
    assign o_in_ready      = (r_count != CNT_W'(DEPTH));
    assign w_push          = i_in_valid && o_in_ready;

    // NOTE: every output of this block gets a default first, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_capture    = 1'b0;
        w_consume    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fifo_nonempty) begin
                    w_pop        = 1'b1;
                    w_next_state = S_START;
                end
            end
            S_START: w_next_state = S_WAIT;
            S_WAIT: begin
                // A done flag seen before the wait count expires is left over from the previous job.
                if ((r_wait_cnt == '0) && i_mul_ready) begin
                    w_capture    = 1'b1;
                    w_next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (i_out_ready) begin
                    w_consume = 1'b1;
                    if (w_fifo_nonempty) begin
                        w_pop        = 1'b1;
                        w_next_state = S_START;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // NOTE: storage array is deliberately not reset; the count and pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mult[r_wr_ptr]  <= i_in_multiplier;
            r_fifo_mcand[r_wr_ptr] <= i_in_multiplicand;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_mult  <= '0;
            r_op_mcand <= '0;
            r_wait_cnt <= '0;
        end else begin
            if (w_pop) begin
                r_op_mult  <= r_fifo_mult[r_rd_ptr];
                r_op_mcand <= r_fifo_mcand[r_rd_ptr];
            end
            if (r_state == S_START)
                r_wait_cnt <= WAIT_W'(MIN_WAIT);
            else if ((r_state == S_WAIT) && (r_wait_cnt != '0))
                r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_product <= '0;
            r_done_count  <= '0;
        end else begin
            if (w_capture) begin
                r_out_valid   <= 1'b1;
                r_out_product <= i_product_in;
            end else if (w_consume) begin
                r_out_valid <= 1'b0;
            end
            if (w_consume) r_done_count <= r_done_count + 16'd1;
        end
    end

    assign o_run              = (r_state == S_START);
    assign o_multiplier_out   = r_op_mult;
    assign o_multiplicand_out = r_op_mcand;
    assign o_out_valid        = r_out_valid;
    assign o_out_product      = r_out_product;
    assign o_busy             = (r_state != S_IDLE) || w_fifo_nonempty;
    assign o_done_count       = r_done_count;

endmodule
